// File: rtl/sha_core_multi.sv
// SHA-256 compression core with UNROLL rounds per clock and optional second pass (SHA-256d).
// State table:  IDLE | waiting for start | ROUND | applying UNROLL rounds per cycle | FINAL | add-back, then finish or begin second pass
module sha_core_multi #(
  parameter int UNROLL        = 1,
  parameter bit ENABLE_DOUBLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         double_hash,
  input  logic [255:0] start_state,
  input  logic [511:0] input_message,
  output logic         ready,
  output logic         done,
  output logic         result_valid,
  output logic [255:0] result
);

  generate
    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
      $error("sha_core_multi: UNROLL must be 1, 2, 4 or 8");
    end
  endgenerate

  localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

  state_t      state, state_next;
  logic        accept;
  logic        dbl;
  logic        pass;
  logic [5:0]  round;
  logic [31:0] work [8];
  logic [31:0] base [8];
  logic [31:0] win [16];
  logic [31:0] w_use [UNROLL];
  logic [31:0] win_next [16];
  logic [31:0] rnd [8];
  logic [31:0] digest [8];

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Extend the window by UNROLL words so later words can depend on ones produced this cycle.
  always_comb begin : sched
    logic [31:0] x [16+UNROLL];
    for (int i = 0; i < 16; i++) x[i] = win[i];
    for (int j = 0; j < UNROLL; j++)
      x[16+j] = ssig1(x[j+14]) + x[j+9] + ssig0(x[j+1]) + x[j];
    for (int i = 0; i < UNROLL; i++) w_use[i] = x[i];
    for (int i = 0; i < 16; i++) win_next[i] = x[i+UNROLL];
  end

  always_comb begin : compress
    logic [31:0] v [8];
    logic [31:0] t1;
    logic [31:0] t2;
    t1 = '0;
    t2 = '0;
    for (int k = 0; k < 8; k++) v[k] = work[k];
    for (int i = 0; i < UNROLL; i++) begin
      t1 = v[7] + bsig1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[round + 6'(i)] + w_use[i];
      t2 = bsig0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6];
      v[6] = v[5];
      v[5] = v[4];
      v[4] = v[3] + t1;
      v[3] = v[2];
      v[2] = v[1];
      v[1] = v[0];
      v[0] = t1 + t2;
    end
    for (int k = 0; k < 8; k++) rnd[k] = v[k];
  end

  always_comb begin
    for (int k = 0; k < 8; k++) digest[k] = work[k] + base[k];
  end

  // ready stays low during the done cycle so a start there is ignored.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    ready      = (state == IDLE) && !done;
    case (state)
      IDLE:    if (start && ready) begin
                 accept     = 1'b1;
                 state_next = ROUND;
               end
      ROUND:   if (round == 6'(64 - UNROLL)) state_next = FINAL;
      FINAL:   state_next = (dbl && !pass) ? ROUND : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      done         <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      round        <= '0;
      pass         <= 1'b0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        IDLE:  if (accept) begin
                 round        <= '0;
                 pass         <= 1'b0;
                 result_valid <= 1'b0;
               end
        ROUND: round <= round + 6'(UNROLL);
        FINAL: if (dbl && !pass) begin
                 pass  <= 1'b1;
                 round <= '0;
               end else begin
                 result       <= {digest[0], digest[1], digest[2], digest[3],
                                  digest[4], digest[5], digest[6], digest[7]};
                 done         <= 1'b1;
                 result_valid <= 1'b1;
               end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      dbl <= double_hash & ENABLE_DOUBLE;
      for (int k = 0; k < 8; k++) begin
        work[k] <= start_state[255-32*k -: 32];
        base[k] <= start_state[255-32*k -: 32];
      end
      for (int i = 0; i < 16; i++) win[i] <= input_message[511-32*i -: 32];
    end else if (state == ROUND) begin
      work <= rnd;
      win  <= win_next;
    end else if (state == FINAL && dbl && !pass) begin
      for (int k = 0; k < 8; k++) begin
        work[k] <= IV[255-32*k -: 32];
        base[k] <= IV[255-32*k -: 32];
        win[k]  <= digest[k];
      end
      win[8] <= 32'h80000000;
      for (int i = 9; i < 15; i++) win[i] <= 32'h0;
      win[15] <= 32'h00000100;
    end
  end

endmodule

// File: doc/sha_core_multi.md
SHA_CORE_MULTI -- requirements
Module: sha_core_multi

Interface
REQ-001 Parameter UNROLL, default 1: SHA-256 rounds per clock; legal values 1, 2, 4, 8; any other value is an elaboration error.
REQ-002 Parameter ENABLE_DOUBLE, default 1: 1 = double-hash (SHA-256d) mode available; 0 = double_hash input ignored and logic removed.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous reset, active-low; block resets when rst=0 at a rising edge.
REQ-005 start  input  1  request; accepted only when ready=1.
REQ-006 double_hash  input  1  sampled with start; 1 = hash the 256-bit digest a second time.
REQ-007 start_state  input  256  chaining value H0..H7, H0 in bits [255:224].
REQ-008 input_message  input  512  block W0..W15, W0 in bits [511:480].
REQ-009 ready  output  1  high in IDLE only.
REQ-010 done  output  1  one-cycle pulse when result becomes valid.
REQ-011 result_valid  output  1  high from done until the next accepted start or reset.
REQ-012 result  output  256  final digest, same word order as start_state.

Function
REQ-013 States: IDLE, ROUND, FINAL, with an internal pass flag (0 = first pass, 1 = second pass).
REQ-014 IDLE with start=1: capture start_state as working state and as add-back base, capture input_message, latch double_hash AND ENABLE_DOUBLE, clear round counter and pass flag, clear result_valid, go to ROUND.
REQ-015 IDLE with start=0: hold all registers; result and result_valid unchanged.
REQ-016 Inputs start_state, input_message and double_hash are don't-care after the accept edge; the block holds its own copies.
REQ-017 ROUND: each cycle applies UNROLL consecutive rounds, using K[t] and W[t] for t = round..round+UNROLL-1, and advances round by UNROLL.
REQ-018 ROUND stays for exactly 64/UNROLL cycles, then goes to FINAL.
REQ-019 Message schedule: W[t] = W[t-16] + s0(W[t-15]) + W[t-7] + s1(W[t-2]) for t >= 16, computed for every W consumed in that cycle, and held in a 16-word sliding window.
REQ-020 FINAL: digest = working state + add-back base, word-wise modulo 2^32, no carry between words.
REQ-021 FINAL, single pass or second pass complete: load result with digest, assert done for one cycle, set result_valid, go to IDLE.
REQ-022 FINAL, double mode and pass=0: load working state and add-back base with the standard IV 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
REQ-023 In that same cycle, load the message window with {digest, 80000000, six zero words, 00000100}, set pass=1, clear round, go to ROUND.
REQ-024 Latency from accept edge to done-high cycle: 64/UNROLL+1 cycles in single mode; 2*(64/UNROLL+1) cycles in double mode.
REQ-025 start while busy (ready=0) is ignored with no effect; a start in the same cycle as done is ignored, because ready is still 0.
REQ-026 Back-to-back operation: start in the first IDLE cycle after done is accepted; minimum spacing is latency+1 cycles.

Reset
REQ-027 At any edge with rst=0, from any state including mid-ROUND or FINAL of either pass: go to IDLE.
REQ-028 Reset also sets ready=1, done=0, result_valid=0, result=0, round=0, pass=0; no partial digest is ever presented.
REQ-029 The working state, message window and add-back base need no reset value.
REQ-030 Deasserting rst and asserting start in the same cycle: start is accepted on that edge.

Verification
REQ-031 Single hash of "abc": IV start_state, block 61626380 00..00 00000018, double_hash=0.
  Expect result ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
  Expect done exactly 65 cycles after accept with UNROLL=1, and 9 cycles with UNROLL=8.
REQ-032 Same block with double_hash=1: expect result 4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358.
  Expect done after 130 cycles with UNROLL=1.
  With ENABLE_DOUBLE=0: expect the REQ-031 digest after 65 cycles.
REQ-033 Pulse start every cycle during a busy run: expect one done only, an unchanged result, and ready low throughout the run.
REQ-034 rst=0 at round 30 of pass 1 in double mode: expect ready=1, result_valid=0, result=0 on the next cycle.
  Then run "abc" and expect the REQ-031 digest.
REQ-035 Two back-to-back runs with different start_state, second start in the first ready cycle.
  Expect both results to match a reference model, result_valid to drop on the second accept, and done to pulse twice.
REQ-036 Randomised 1000 blocks per legal UNROLL, with random double_hash and random input changes after accept: all results match the software model.
